// File: rtl/sdram_68k_pkg.sv
// Shared types and timing constants for the 68K SDRAM controller and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: arbiter state enum, grant encoding, controller timing constants and
// the derived default for the arbiter's fixed per-access strobe window.
package sdram_68k_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ACC  = 3'd1,
    VID_ACC  = 3'd2,
    CPU_DONE = 3'd3,
    GAP      = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VID = 1'b1
  } grant_t;

  // Controller timing, in clk100_mhz cycles / controller state numbers.
  localparam int RAS_CAS_CYCLES  = 3;
  localparam int CAS_LATENCY     = 2;
  localparam int CTRL_LAST_STATE = 7;
  localparam int REFRESH_CYCLES  = 7;

  // Length of one controller access: it runs to its last state, which must not
  // come before the read data slot.
  function automatic int access_cycles();
    int read_slot;
    read_slot = RAS_CAS_CYCLES + CAS_LATENCY;
    return ((CTRL_LAST_STATE > read_slot) ? CTRL_LAST_STATE : read_slot) + 1;
  endfunction

  // Worst case: the request lands just as a refresh starts, so a full refresh
  // then a full access, plus one cycle of margin.
  localparam int ACK_CYCLES_DFLT = REFRESH_CYCLES + access_cycles() + 1;

  // Shared access/gap counter; must hold ACK_CYCLES (video ack cycle).
  localparam int CNT_W = 5;

endpackage

// File: rtl/sdram_arb_68k.sv
// Two-port arbiter (68000 CPU bus + read-only video fetch) in front of the SDRAM controller.
// Latency: mem strobes low for ACK_CYCLES after grant; DTACK / vid_ack at grant edge + ACK_CYCLES + 1.
// Backpressure: CPU held via cpu_dtackn until cpu_asn rises; video holds vid_req until vid_ack.
//
// Ports: clk100_mhz/rst (sync, active-high); cpu_* 68000 bus (active-low strobes,
// cpu_rw 1=read); vid_req/vid_addr in, vid_ack/vid_data out; mem_* drive the
// controller's asn/udsn/ldsn/rw/addr/din and read its dout.
module sdram_arb_68k
  import sdram_68k_pkg::*;
#(
  parameter int ACK_CYCLES = ACK_CYCLES_DFLT,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk100_mhz,
  input  logic        rst,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  input  logic        cpu_asn,
  input  logic        cpu_udsn,
  input  logic        cpu_ldsn,
  input  logic        cpu_rw,
  output logic        cpu_dtackn,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_asn,
  output logic        mem_udsn,
  output logic        mem_ldsn,
  output logic        mem_rw
);

  localparam logic [CNT_W-1:0] CNT_ACK_LAST = CNT_W'(ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ACK      = CNT_W'(ACK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [23:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic              mem_asn_q, mem_asn_d;
  logic              mem_udsn_q, mem_udsn_d;
  logic              mem_ldsn_q, mem_ldsn_d;
  logic              mem_rw_q, mem_rw_d;
  logic [15:0]       cpu_dout_q, cpu_dout_d;
  logic              cpu_dtackn_q, cpu_dtackn_d;
  logic              vid_ack_q, vid_ack_d;
  logic [15:0]       vid_data_q, vid_data_d;

  logic cpu_pend, vid_pend, gnt_cpu;

  assign cpu_pend = !cpu_asn && !(cpu_udsn && cpu_ldsn);
  assign vid_pend = vid_req;
  // On a tie the port that was not served last wins.
  assign gnt_cpu  = cpu_pend && (!vid_pend || (last_grant_q == GNT_VID));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_asn_d    = mem_asn_q;
    mem_udsn_d   = mem_udsn_q;
    mem_ldsn_d   = mem_ldsn_q;
    mem_rw_d     = mem_rw_q;
    cpu_dout_d   = cpu_dout_q;
    cpu_dtackn_d = cpu_dtackn_q;
    vid_ack_d    = 1'b0;
    vid_data_d   = vid_data_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_cpu) begin
          state_d      = CPU_ACC;
          last_grant_d = GNT_CPU;
          abort_d      = 1'b0;
          mem_addr_d   = cpu_addr;
          mem_din_d    = cpu_din;
          mem_udsn_d   = cpu_udsn;
          mem_ldsn_d   = cpu_ldsn;
          mem_rw_d     = cpu_rw;
          mem_asn_d    = 1'b0;
        end else if (vid_pend) begin
          state_d      = VID_ACC;
          last_grant_d = GNT_VID;
          mem_addr_d   = vid_addr;
          mem_udsn_d   = 1'b0;
          mem_ldsn_d   = 1'b0;
          mem_rw_d     = 1'b1;
          mem_asn_d    = 1'b0;
        end
      end

      CPU_ACC: begin
        // A CPU that walks away mid-access gets no DTACK, even if it
        // re-asserts cpu_asn before the access finishes.
        if (cpu_asn) abort_d = 1'b1;
        if (cnt_q == CNT_ACK_LAST) begin
          if (mem_rw_q) cpu_dout_d = mem_dout;
          mem_asn_d  = 1'b1;
          mem_udsn_d = 1'b1;
          mem_ldsn_d = 1'b1;
          cnt_d      = '0;
          state_d    = (abort_q || cpu_asn) ? GAP : CPU_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      VID_ACC: begin
        // The counter runs one past the capture point so the ack pulse lands
        // one edge after the data, matching the CPU DTACK timing.
        if (cnt_q == CNT_ACK) begin
          vid_ack_d = 1'b1;
          cnt_d     = '0;
          state_d   = GAP;
        end else begin
          if (cnt_q == CNT_ACK_LAST) begin
            vid_data_d = mem_dout;
            mem_asn_d  = 1'b1;
            mem_udsn_d = 1'b1;
            mem_ldsn_d = 1'b1;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CPU_DONE: begin
        if (cpu_asn) begin
          cpu_dtackn_d = 1'b1;
          cnt_d        = '0;
          state_d      = GAP;
        end else begin
          cpu_dtackn_d = 1'b0;
        end
      end

      GAP: begin
        if (cnt_q == CNT_GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk100_mhz) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_VID;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_asn_q    <= 1'b1;
      mem_udsn_q   <= 1'b1;
      mem_ldsn_q   <= 1'b1;
      mem_rw_q     <= 1'b1;
      cpu_dout_q   <= '0;
      cpu_dtackn_q <= 1'b1;
      vid_ack_q    <= 1'b0;
      vid_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_asn_q    <= mem_asn_d;
      mem_udsn_q   <= mem_udsn_d;
      mem_ldsn_q   <= mem_ldsn_d;
      mem_rw_q     <= mem_rw_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_dtackn_q <= cpu_dtackn_d;
      vid_ack_q    <= vid_ack_d;
      vid_data_q   <= vid_data_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_asn    = mem_asn_q;
  assign mem_udsn   = mem_udsn_q;
  assign mem_ldsn   = mem_ldsn_q;
  assign mem_rw     = mem_rw_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_dtackn = cpu_dtackn_q;
  assign vid_ack    = vid_ack_q;
  assign vid_data   = vid_data_q;

endmodule

// File: tb/tb_sdram_arb_68k.sv
// Bench for sdram_arb_68k: directed scenarios plus randomized single-port traffic,
// checked against a word-level memory reference and the arbiter's timing rules.
module tb_sdram_arb_68k;

  logic        clk100_mhz = 1'b0;
  logic        rst;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_asn, cpu_udsn, cpu_ldsn, cpu_rw;
  logic        cpu_dtackn;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = 16'h0BAD;
  logic        mem_asn, mem_udsn, mem_ldsn, mem_rw;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_cpu_dout = 16'h0000;

  always #5 clk100_mhz = ~clk100_mhz;

  sdram_arb_68k dut (
    .clk100_mhz (clk100_mhz),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_asn    (cpu_asn),
    .cpu_udsn   (cpu_udsn),
    .cpu_ldsn   (cpu_ldsn),
    .cpu_rw     (cpu_rw),
    .cpu_dtackn (cpu_dtackn),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_data   (vid_data),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_asn    (mem_asn),
    .mem_udsn   (mem_udsn),
    .mem_ldsn   (mem_ldsn),
    .mem_rw     (mem_rw)
  );

  // ---------------- memory contents: controller side and reference side ----------------
  logic [15:0] mem_store [logic [23:0]];
  logic [15:0] ref_mem   [logic [23:0]];
  int          low_cnt = 0;

  function automatic logic [15:0] init_word(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] store_rd(input logic [23:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic u, input logic l);
    return {u ? old_w[15:8] : new_w[15:8], l ? old_w[7:0] : new_w[7:0]};
  endfunction

  // Controller stand-in: read data only valid late in the strobe window,
  // writes committed part-way through it using the byte strobes.
  always @(posedge clk100_mhz) begin
    if (rst || mem_asn) low_cnt <= 0;
    else                low_cnt <= low_cnt + 1;
    mem_dout <= (!mem_asn && mem_rw && low_cnt >= 9) ? store_rd(mem_addr) : 16'h0BAD;
    if (!rst && !mem_asn && !mem_rw && low_cnt == 12)
      mem_store[mem_addr] = merge(store_rd(mem_addr), mem_din, mem_udsn, mem_ldsn);
  end

  // Grant order: a falling mem_asn marks a new access; bit 23 tells video (1) from CPU (0)
  // in the contention scenario.
  logic log_prev = 1'b1;
  logic grant_log [$];
  always @(negedge clk100_mhz) begin
    if (log_prev && !mem_asn) grant_log.push_back(mem_addr[23]);
    log_prev <= mem_asn;
  end

  // ---------------- stimulus/measurement helpers (start and end #1 after a posedge) ----------------
  task automatic run_cpu(input logic [23:0] a, input logic [15:0] d, input logic u, input logic l,
                         input logic rw, input int drop_k, output int dt_k, output int rel_k,
                         output int rel_dt, output logic sig_ok, output logic [15:0] dout_at);
    cpu_addr = a; cpu_din = d; cpu_udsn = u; cpu_ldsn = l; cpu_rw = rw; cpu_asn = 1'b0;
    dt_k = -1; rel_k = -1; rel_dt = -1; sig_ok = 1'b1; dout_at = 16'h0;
    for (int k = 0; k < 40 && dt_k < 0; k++) begin
      @(posedge clk100_mhz); #1;
      if (k == drop_k) begin cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1; end
      if (rel_k < 0 && mem_asn) rel_k = k;
      if (rel_k < 0 && !(mem_addr == a && mem_udsn == u && mem_ldsn == l &&
                         mem_rw == rw && mem_din == d)) sig_ok = 1'b0;
      if (!cpu_dtackn) begin dt_k = k; dout_at = cpu_dout; end
    end
    cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1;
    for (int w = 1; w <= 10 && rel_dt < 0; w++) begin
      @(posedge clk100_mhz); #1;
      if (cpu_dtackn) rel_dt = w;
    end
    repeat (4) @(posedge clk100_mhz);
    #1;
  endtask

  task automatic run_vid(input logic [23:0] a, input int drop_k, output int ack_k, output int ack_n,
                         output int rel_k, output logic sig_ok, output logic [15:0] dat);
    vid_addr = a; vid_req = 1'b1;
    ack_k = -1; ack_n = 0; rel_k = -1; sig_ok = 1'b1; dat = 16'h0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk100_mhz); #1;
      if (k == drop_k) vid_req = 1'b0;
      if (rel_k < 0 && mem_asn) rel_k = k;
      if (rel_k < 0 && !(mem_addr == a && !mem_udsn && !mem_ldsn && mem_rw)) sig_ok = 1'b0;
      if (vid_ack) begin
        ack_n++;
        if (ack_k < 0) begin ack_k = k; dat = vid_data; end
        vid_req = 1'b0;
      end
    end
    vid_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_din = '0; vid_req = 1'b0; vid_addr = '0;
    repeat (3) @(posedge clk100_mhz);
    #1;
    tests_run++; if (mem_asn !== 1'b1)    begin tests_failed++; $display("FAIL reset_mem_asn got %b want 1", mem_asn); end
    tests_run++; if (mem_udsn !== 1'b1)   begin tests_failed++; $display("FAIL reset_mem_udsn got %b want 1", mem_udsn); end
    tests_run++; if (mem_ldsn !== 1'b1)   begin tests_failed++; $display("FAIL reset_mem_ldsn got %b want 1", mem_ldsn); end
    tests_run++; if (mem_rw !== 1'b1)     begin tests_failed++; $display("FAIL reset_mem_rw got %b want 1", mem_rw); end
    tests_run++; if (mem_addr !== 24'h0)  begin tests_failed++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests_run++; if (mem_din !== 16'h0)   begin tests_failed++; $display("FAIL reset_mem_din got %h want 0", mem_din); end
    tests_run++; if (cpu_dout !== 16'h0)  begin tests_failed++; $display("FAIL reset_cpu_dout got %h want 0", cpu_dout); end
    tests_run++; if (vid_data !== 16'h0)  begin tests_failed++; $display("FAIL reset_vid_data got %h want 0", vid_data); end
    tests_run++; if (cpu_dtackn !== 1'b1) begin tests_failed++; $display("FAIL reset_cpu_dtackn got %b want 1", cpu_dtackn); end
    tests_run++; if (vid_ack !== 1'b0)    begin tests_failed++; $display("FAIL reset_vid_ack got %b want 0", vid_ack); end
    rst = 1'b0;
    repeat (2) @(posedge clk100_mhz);
    #1;
    tests_run++; if (mem_asn !== 1'b1)    begin tests_failed++; $display("FAIL idle_no_request_mem_asn got %b want 1", mem_asn); end
    exp_cpu_dout = 16'h0;
  endtask

  task automatic test_cpu_read();
    int dt_k, rel_k, rel_dt; logic sig_ok; logic [15:0] dout_at;
    mem_store[24'h000123] = 16'hBEEF; ref_mem[24'h000123] = 16'hBEEF;
    run_cpu(24'h000123, 16'h0000, 1'b0, 1'b0, 1'b1, -1, dt_k, rel_k, rel_dt, sig_ok, dout_at);
    tests_run++; if (dt_k !== 17)         begin tests_failed++; $display("FAIL cpu_read_dtack_edge got %0d want 17", dt_k); end
    tests_run++; if (rel_k !== 16)        begin tests_failed++; $display("FAIL cpu_read_strobe_window got %0d want 16", rel_k); end
    tests_run++; if (sig_ok !== 1'b1)     begin tests_failed++; $display("FAIL cpu_read_mem_signals got %b want 1", sig_ok); end
    tests_run++; if (dout_at !== 16'hBEEF) begin tests_failed++; $display("FAIL cpu_read_data got %h want beef", dout_at); end
    tests_run++; if (rel_dt !== 1)        begin tests_failed++; $display("FAIL cpu_read_dtack_release got %0d want 1", rel_dt); end
    exp_cpu_dout = 16'hBEEF;
  endtask

  task automatic test_byte_write();
    int dt_k, rel_k, rel_dt; logic sig_ok; logic [15:0] dout_at;
    run_cpu(24'h000123, 16'h55AA, 1'b1, 1'b0, 1'b0, -1, dt_k, rel_k, rel_dt, sig_ok, dout_at);
    ref_mem[24'h000123] = merge(ref_rd(24'h000123), 16'h55AA, 1'b1, 1'b0);
    tests_run++; if (dt_k !== 17)         begin tests_failed++; $display("FAIL byte_write_dtack_edge got %0d want 17", dt_k); end
    tests_run++; if (rel_k !== 16)        begin tests_failed++; $display("FAIL byte_write_strobe_window got %0d want 16", rel_k); end
    tests_run++; if (sig_ok !== 1'b1)     begin tests_failed++; $display("FAIL byte_write_mem_signals got %b want 1", sig_ok); end
    tests_run++; if (dout_at !== 16'hBEEF) begin tests_failed++; $display("FAIL byte_write_dout_kept got %h want beef", dout_at); end
    // Read back: only the low byte may have changed.
    run_cpu(24'h000123, 16'h0000, 1'b0, 1'b0, 1'b1, -1, dt_k, rel_k, rel_dt, sig_ok, dout_at);
    tests_run++; if (dout_at !== 16'hBEAA) begin tests_failed++; $display("FAIL byte_write_readback got %h want beaa", dout_at); end
    exp_cpu_dout = 16'hBEAA;
  endtask

  task automatic test_video();
    int ack_k, ack_n, rel_k; logic sig_ok; logic [15:0] dat;
    mem_store[24'h100000] = 16'h1234; ref_mem[24'h100000] = 16'h1234;
    run_vid(24'h100000, -1, ack_k, ack_n, rel_k, sig_ok, dat);
    tests_run++; if (ack_k !== 17)      begin tests_failed++; $display("FAIL video_ack_edge got %0d want 17", ack_k); end
    tests_run++; if (ack_n !== 1)       begin tests_failed++; $display("FAIL video_ack_width got %0d want 1", ack_n); end
    tests_run++; if (rel_k !== 16)      begin tests_failed++; $display("FAIL video_strobe_window got %0d want 16", rel_k); end
    tests_run++; if (sig_ok !== 1'b1)   begin tests_failed++; $display("FAIL video_mem_signals got %b want 1", sig_ok); end
    tests_run++; if (dat !== 16'h1234)  begin tests_failed++; $display("FAIL video_data got %h want 1234", dat); end
  endtask

  task automatic test_cpu_abort();
    int dt_k, rel_k, rel_dt; logic sig_ok; logic [15:0] dout_at;
    run_cpu(24'h000300, 16'h0000, 1'b0, 1'b0, 1'b1, 5, dt_k, rel_k, rel_dt, sig_ok, dout_at);
    tests_run++; if (dt_k !== -1)  begin tests_failed++; $display("FAIL abort_no_dtack got %0d want -1", dt_k); end
    tests_run++; if (rel_k !== 16) begin tests_failed++; $display("FAIL abort_strobe_window got %0d want 16", rel_k); end
    exp_cpu_dout = ref_rd(24'h000300);
  endtask

  task automatic test_vid_drop();
    int ack_k, ack_n, rel_k; logic sig_ok; logic [15:0] dat;
    run_vid(24'h100002, 3, ack_k, ack_n, rel_k, sig_ok, dat);
    tests_run++; if (ack_k !== 17) begin tests_failed++; $display("FAIL vid_drop_ack_edge got %0d want 17", ack_k); end
    tests_run++; if (ack_n !== 1)  begin tests_failed++; $display("FAIL vid_drop_ack_width got %0d want 1", ack_n); end
    tests_run++; if (dat !== ref_rd(24'h100002)) begin tests_failed++; $display("FAIL vid_drop_data got %h want %h", dat, ref_rd(24'h100002)); end
  endtask

  task automatic test_random();
    int dt_k, rel_k, rel_dt, ack_k, ack_n, drop, kind, sel;
    logic sig_ok, u, l; logic [15:0] d, got, want; logic [23:0] a;
    for (int n = 0; n < 16; n++) begin
      a    = 24'h000040 + 24'($urandom_range(0, 7));
      kind = $urandom_range(0, 2);
      if (kind == 2) begin
        drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
        want = ref_rd(a);
        run_vid(a, drop, ack_k, ack_n, rel_k, sig_ok, got);
        tests_run++; if (ack_k !== 17 || ack_n !== 1) begin tests_failed++; $display("FAIL rand_vid_ack[%0d] got edge %0d count %0d want 17 1", n, ack_k, ack_n); end
        tests_run++; if (sig_ok !== 1'b1 || rel_k !== 16) begin tests_failed++; $display("FAIL rand_vid_mem[%0d] got ok %b window %0d want 1 16", n, sig_ok, rel_k); end
        tests_run++; if (got !== want) begin tests_failed++; $display("FAIL rand_vid_data[%0d] got %h want %h", n, got, want); end
      end else begin
        sel = $urandom_range(0, 2);
        u = (sel == 2); l = (sel == 1);
        d = 16'($urandom);
        want = (kind == 0) ? ref_rd(a) : exp_cpu_dout;
        run_cpu(a, d, u, l, (kind == 0), -1, dt_k, rel_k, rel_dt, sig_ok, got);
        if (kind == 1) ref_mem[a] = merge(ref_rd(a), d, u, l);
        else           exp_cpu_dout = want;
        tests_run++; if (dt_k !== 17) begin tests_failed++; $display("FAIL rand_cpu_dtack[%0d] got %0d want 17", n, dt_k); end
        tests_run++; if (sig_ok !== 1'b1 || rel_k !== 16) begin tests_failed++; $display("FAIL rand_cpu_mem[%0d] got ok %b window %0d want 1 16", n, sig_ok, rel_k); end
        tests_run++; if (got !== want) begin tests_failed++; $display("FAIL rand_cpu_dout[%0d] got %h want %h", n, got, want); end
      end
    end
  endtask

  task automatic test_reset_mid_vid();
    int ack_k, ack_n, rel_k; logic sig_ok; logic [15:0] dat;
    vid_addr = 24'h100004; vid_req = 1'b1;
    repeat (7) @(posedge clk100_mhz);
    #1;
    rst = 1'b1;
    @(posedge clk100_mhz); #1;
    tests_run++; if (mem_asn !== 1'b1 || mem_udsn !== 1'b1 || mem_ldsn !== 1'b1)
      begin tests_failed++; $display("FAIL rst_mid_strobes got %b%b%b want 111", mem_asn, mem_udsn, mem_ldsn); end
    tests_run++; if (vid_ack !== 1'b0)   begin tests_failed++; $display("FAIL rst_mid_vid_ack got %b want 0", vid_ack); end
    tests_run++; if (vid_data !== 16'h0) begin tests_failed++; $display("FAIL rst_mid_vid_data got %h want 0", vid_data); end
    tests_run++; if (mem_addr !== 24'h0) begin tests_failed++; $display("FAIL rst_mid_mem_addr got %h want 0", mem_addr); end
    vid_req = 1'b0; rst = 1'b0;
    exp_cpu_dout = 16'h0;
    @(posedge clk100_mhz); #1;
    run_vid(24'h100004, -1, ack_k, ack_n, rel_k, sig_ok, dat);
    tests_run++; if (ack_k !== 17) begin tests_failed++; $display("FAIL rst_mid_restart_ack got %0d want 17", ack_k); end
  endtask

  task automatic test_contention();
    logic cpu_got, vid_got;
    rst = 1'b1;
    repeat (2) @(posedge clk100_mhz);
    #1;
    grant_log.delete();
    cpu_asn = 1'b0; cpu_udsn = 1'b0; cpu_ldsn = 1'b0; cpu_rw = 1'b1; cpu_addr = 24'h000200;
    vid_req = 1'b1; vid_addr = 24'h800000;
    rst = 1'b0;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          cpu_addr = 24'h000200 + 24'(i); cpu_asn = 1'b0; cpu_udsn = 1'b0; cpu_ldsn = 1'b0;
          cpu_got = 1'b0;
          for (int w = 0; w < 100 && !cpu_got; w++) begin
            @(posedge clk100_mhz); #1;
            if (!cpu_dtackn) cpu_got = 1'b1;
          end
          tests_run++;
          if (!cpu_got) begin tests_failed++; $display("FAIL contention_cpu_dtack[%0d] got timeout want dtack", i); end
          else if (cpu_dout !== ref_rd(24'h000200 + 24'(i))) begin tests_failed++; $display("FAIL contention_cpu_data[%0d] got %h want %h", i, cpu_dout, ref_rd(24'h000200 + 24'(i))); end
          cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1;
          @(posedge clk100_mhz); #1;
        end
      end
      begin
        for (int i = 0; i < 2; i++) begin
          vid_addr = 24'h800000 + 24'(i); vid_req = 1'b1;
          vid_got = 1'b0;
          for (int w = 0; w < 100 && !vid_got; w++) begin
            @(posedge clk100_mhz); #1;
            if (vid_ack) vid_got = 1'b1;
          end
          tests_run++;
          if (!vid_got) begin tests_failed++; $display("FAIL contention_vid_ack[%0d] got timeout want ack", i); end
          else if (vid_data !== ref_rd(24'h800000 + 24'(i))) begin tests_failed++; $display("FAIL contention_vid_data[%0d] got %h want %h", i, vid_data, ref_rd(24'h800000 + 24'(i))); end
        end
        vid_req = 1'b0;
      end
    join
    repeat (25) @(posedge clk100_mhz);
    #1;
    tests_run++; if (grant_log.size() !== 4) begin tests_failed++; $display("FAIL contention_grant_count got %0d want 4", grant_log.size()); end
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
      // Reset leaves the video port as last served, so the CPU takes the first tie
      // and the ports then alternate.
      tests_run++;
      if (grant_log[i] !== logic'(i % 2)) begin tests_failed++; $display("FAIL contention_order[%0d] got %b want %b", i, grant_log[i], logic'(i % 2)); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_byte_write();
    test_video();
    test_cpu_abort();
    test_vid_drop();
    test_random();
    test_reset_mid_vid();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_arb_68k.md
# sdram_arb_68k

Two-port arbiter placed directly upstream of the 68K-style SDRAM controller. It multiplexes the 68000 CPU bus and a read-only video fetch port onto the controller's single asn/udsn/ldsn/rw/addr interface. The controller has no ready output, so the arbiter times every access with a fixed, worst-case cycle count and then generates CPU DTACK or a video acknowledge. Everything runs on clk100_mhz; CPU bus inputs are synchronous to it.

## Interface
Parameters:
- ACK_CYCLES, 16, cycles mem strobes stay asserted per access; covers a full refresh (7) plus a full access (8) plus 1 margin.
- GAP_CYCLES, 2, idle cycles with mem_asn high between accesses, so the controller leaves its last state.

Ports:
- clk100_mhz  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cpu_addr  in  24  CPU word address
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  CPU read data
- cpu_asn, cpu_udsn, cpu_ldsn  in  1 each  CPU address/upper/lower strobes, active-low
- cpu_rw  in  1  1=read, 0=write
- cpu_dtackn  out  1  data acknowledge, active-low
- vid_req  in  1  video fetch request, level, held until vid_ack
- vid_addr  in  24  video word address, stable while vid_req
- vid_ack  out  1  one-cycle completion pulse
- vid_data  out  16  fetched word
- mem_addr  out  24  to controller addr
- mem_din  out  16  to controller din
- mem_dout  in  16  from controller dout
- mem_asn, mem_udsn, mem_ldsn, mem_rw  out  1 each  to controller strobes/rw

## Operation
- Reset values:
  - mem_asn, mem_udsn and mem_ldsn are 1; mem_rw is 1.
  - mem_addr, mem_din, cpu_dout and vid_data are 0.
  - cpu_dtackn is 1 and vid_ack is 0.
  - The state is IDLE, the counter is 0 and last_grant is VID, so the CPU wins the first tie.
- cpu_pend = !cpu_asn & !(cpu_udsn & cpu_ldsn). vid_pend = vid_req.
- IDLE:
  - If both ports are pending, grant the port not equal to last_grant.
  - If one port is pending, grant it. If none, stay in IDLE.
  - On grant, latch the address into mem_addr and update last_grant.
  - CPU grant: latch cpu_din into mem_din, {cpu_udsn, cpu_ldsn} into mem strobes and cpu_rw into mem_rw; go to CPU_ACC.
  - Video grant: mem strobes are 00 and mem_rw is 1; go to VID_ACC.
  - mem_asn goes to 0 at the same time.
- CPU_ACC / VID_ACC:
  - The counter runs 0..ACK_CYCLES-1.
  - On count ACK_CYCLES-1, capture mem_dout and drive mem_asn, mem_udsn and mem_ldsn to 1.
  - CPU reads capture into cpu_dout; CPU writes leave cpu_dout unchanged. Video captures into vid_data.
  - From CPU_ACC, next state is CPU_DONE. From VID_ACC, vid_ack=1 for one cycle, then GAP.
- CPU_DONE:
  - cpu_dtackn=0 while cpu_asn=0.
  - When cpu_asn is sampled 1, set cpu_dtackn=1 and go to GAP.
- GAP: hold mem_asn high for GAP_CYCLES, then go to IDLE.
- Boundary cases:
  - CPU drops cpu_asn mid-access: the memory access still completes; the state machine skips asserting DTACK and goes CPU_ACC→GAP.
  - vid_req drops before vid_ack: the access completes and vid_ack still pulses.
  - Back-to-back requests are served with strict alternation when both ports are pending.
  - rst mid-access aborts to reset values on the next edge; the controller resets on the same rst.

## Timing
- Request sampled in IDLE at edge E: mem_asn is low from E+1 through E+ACK_CYCLES.
- Data is captured at edge E+ACK_CYCLES.
- cpu_dtackn falls, or vid_ack pulses, at edge E+ACK_CYCLES+1.
- Minimum CPU-to-CPU spacing: ACK_CYCLES+1 edges, plus the DTACK hold until cpu_asn rises, plus GAP_CYCLES+1 edges.
- Video throughput: one word per ACK_CYCLES+GAP_CYCLES+2 cycles, i.e. 20 at defaults.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package sdram_68k_pkg holds:
  - the state enum (IDLE, CPU_ACC, VID_ACC, CPU_DONE, GAP);
  - grant encoding CPU=0, VID=1;
  - controller timing constants (RAS-CAS 3, CAS latency 2, last state 7, refresh length 7), from which the ACK_CYCLES default is derived.
- The counter is a single 5-bit counter, shared by the access and GAP states.
- No sub-module; the arbiter is one flat FSM.

## Test plan
- CPU read: cpu_addr=0x000123, strobes 00, and a controller model returning 0xBEEF at its read slot → cpu_dout=0xBEEF and cpu_dtackn low exactly 17 edges after the request is sampled.
- CPU byte write: cpu_udsn=1, cpu_ldsn=0, cpu_din=0x55AA → mem_udsn=1, mem_ldsn=0, mem_rw=0, mem_din=0x55AA held for 16 cycles; cpu_dout unchanged.
- Video read: vid_req with vid_addr=0x100000, model data 0x1234 → vid_ack pulses one cycle with vid_data=0x1234; mem_rw=1, strobes 00.
- Contention: CPU and video pending in the same IDLE cycle after reset → CPU served first, then video, then CPU, with no back-to-back grants to the same port.
- Abort and reset:
  - cpu_asn raised at count 5 → no DTACK, mem_asn still low until count 15.
  - rst asserted mid-VID_ACC → next edge all mem strobes are 1, vid_ack=0, state IDLE.
